// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: default sizes, command codes
// and the nand-derived single-bit gate helpers used by the datapath.
package pc_pkg;

  localparam int PC_WIDTH_DEFAULT     = 16;
  localparam int PC_RESET_VAL_DEFAULT = 0;

  localparam logic [1:0] CMD_HOLD  = 2'd0;
  localparam logic [1:0] CMD_INC   = 2'd1;
  localparam logic [1:0] CMD_LOAD  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  function automatic logic g_nand(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic g_not(input logic a);
    return g_nand(a, a);
  endfunction

  function automatic logic g_and(input logic a, input logic b);
    return g_not(g_nand(a, b));
  endfunction

  function automatic logic g_or(input logic a, input logic b);
    return g_nand(g_not(a), g_not(b));
  endfunction

  // Classic four-nand xor.
  function automatic logic g_xor(input logic a, input logic b);
    logic n;
    n = g_nand(a, b);
    return g_nand(g_nand(a, n), g_nand(b, n));
  endfunction

  // s ? a : b. A low select forces the a-leg nand high, so X on a is blocked.
  function automatic logic g_mux(input logic s, input logic a, input logic b);
    return g_nand(g_nand(a, s), g_nand(b, g_not(s)));
  endfunction

endpackage

// File: rtl/pc_counter_inc_n.sv
// Ripple incrementer (carry-in fixed at 1) built from nand-only half adders.
module inc_n
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]         = g_xor(a[i], carry_s[i]);
    assign carry_s[i + 1] = g_and(a[i], carry_s[i]);
  end

  assign carry_out = carry_s[WIDTH];

endmodule

// File: rtl/pc_counter.sv
// Program counter with priority clear > load > inc > hold and a one-cycle
// post-reset valid. Defining PC_WRAP_FLAG_EN adds the wrap pulse output.
module pc_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PC_RESET_VAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             valid
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  logic [1:0]       cmd_s;
  logic             sel_clear_s;
  logic             sel_load_s;
  logic             sel_inc_s;
  logic [WIDTH-1:0] inc_sum_s;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] pick_s;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;
  logic             valid_q;

  // Priority encoder producing CMD_HOLD/INC/LOAD/CLEAR, then decoded to one-hot selects.
  assign cmd_s[1]    = g_or(clear, load);
  assign cmd_s[0]    = g_or(clear, g_and(inc, g_not(load)));
  assign sel_clear_s = g_and(cmd_s[1], cmd_s[0]);
  assign sel_load_s  = g_and(cmd_s[1], g_not(cmd_s[0]));
  assign sel_inc_s   = g_and(g_not(cmd_s[1]), cmd_s[0]);

`ifdef PC_WRAP_FLAG_EN
  logic carry_s;
  logic wrap_d;
  logic wrap_q;
`else
  logic carry_unused_s;
`endif

  inc_n #(
    .WIDTH(WIDTH)
  ) u_inc (
    .a        (pc_q),
    .sum      (inc_sum_s),
`ifdef PC_WRAP_FLAG_EN
    .carry_out(carry_s)
`else
    .carry_out(carry_unused_s)
`endif
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_sel
    assign step_s[i] = g_mux(sel_inc_s,   inc_sum_s[i], pc_q[i]);
    assign pick_s[i] = g_mux(sel_load_s,  in[i],        step_s[i]);
    assign pc_d[i]   = g_mux(sel_clear_s, RESET_VAL[i], pick_s[i]);
  end

  // Counter state and post-reset valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

  assign out   = pc_q;
  assign valid = valid_q;

`ifdef PC_WRAP_FLAG_EN
  // Carry out of the incrementer only means a wrap when increment was the chosen command.
  assign wrap_d = g_and(sel_inc_s, carry_s);

  // Registered one-cycle wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_pc_counter.sv
// Scoreboard bench for pc_counter: a command-level reference model queues the
// expected state after each edge; a monitor compares it after the edge.
module tb_pc_counter;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] pc;
    logic         v;
    logic         w;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         clear_d;
  logic         load_d;
  logic         inc_d;
  logic [W-1:0] in_d;
  logic [W-1:0] out_s;
  logic         valid_s;
`ifdef PC_WRAP_FLAG_EN
  logic         wrap_s;
`endif

  exp_t         q[$];
  logic [W-1:0] m_pc;
  int           n_vec = 0;
  int           n_bad = 0;

  pc_counter #(
    .WIDTH    (W),
    .RESET_VAL(16'h0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear_d),
    .load (load_d),
    .inc  (inc_d),
    .in   (in_d),
    .out  (out_s),
    .valid(valid_s)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrap (wrap_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the counter holds after one edge with these commands.
  function automatic exp_t apply_cmd(input logic c, input logic l, input logic i,
                                     input logic [W-1:0] d);
    exp_t e;
    e.w = (!c && !l && i && m_pc == 16'hFFFF);
    if (c)      m_pc = 16'h0000;
    else if (l) m_pc = d;
    else if (i) m_pc = m_pc + 16'd1;
    e.pc = m_pc;
    e.v  = 1'b1;
    return e;
  endfunction

  task automatic step(input logic c, input logic l, input logic i, input logic [W-1:0] d);
    @(negedge clk);
    clear_d = c; load_d = l; inc_d = i; in_d = d;
    q.push_back(apply_cmd(c, l, i, d));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out"}, 32'(out_s), 32'h0);
    chk({tag, "_valid"}, 32'(valid_s), 32'h0);
`ifdef PC_WRAP_FLAG_EN
    chk({tag, "_wrap"}, 32'(wrap_s), 32'h0);
`endif
  endtask

  // Async reset in the low clock phase with current commands left applied,
  // then release carrying the given first command.
  task automatic do_reset(input logic c, input logic l, input logic i, input logic [W-1:0] d);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_state("rst_async");
    m_pc = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst_hold");
    rst_n = 1'b1;
    clear_d = c; load_d = l; inc_d = i; in_d = d;
    q.push_back(apply_cmd(c, l, i, d));
    #1 chk_reset_state("rst_release");
  endtask

  // Monitor: pops one expectation per edge and compares the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out", 32'(out_s), 32'(e.pc));
        chk("valid", 32'(valid_s), 32'(e.v));
`ifdef PC_WRAP_FLAG_EN
        chk("wrap", 32'(wrap_s), 32'(e.w));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] d;
    rst_n = 1'b1; clear_d = 1'b0; load_d = 1'b0; inc_d = 1'b0; in_d = '0;
    m_pc = 16'h0000;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("por_hold");
    rst_n = 1'b1;
    q.push_back(apply_cmd(1'b0, 1'b0, 1'b0, 16'h0000));
    #1 chk_reset_state("por_release");

    repeat (5) step(1'b0, 1'b0, 1'b1, 16'h0000);

    step(1'b0, 1'b1, 1'b0, 16'hFFFE);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 16'h5555);
    step(1'b0, 1'b0, 1'b0, 16'hAAAA);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h7777);

    step(1'b0, 1'b1, 1'b0, 16'h000F);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    do_reset(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h0000);

    step(1'b0, 1'b1, 1'b0, 16'h00A5);
    for (int k = 0; k < 10; k++) begin
      d = (k % 2 == 0) ? 16'($urandom) : 16'bx;
      step(1'b0, 1'b0, 1'b0, d);
    end

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF;
        1:       d = 16'hFFFE;
        default: d = 16'($urandom);
      endcase
      if (k == 150) begin
        do_reset(1'b0, 1'b1, 1'b0, d);
      end else begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) != 0, d);
      end
    end

    @(negedge clk);
    clear_d = 1'b0; load_d = 1'b0; inc_d = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    chk("scoreboard_drain", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
